lights_pwm_driver: RTL and testbench

Downstream stage of the lights controller. Consumes its 3-bit colour code and drives three physical LED channels (red/green/blue) with PWM. Each channel fades linearly toward its on/off target instead of switching hard. Sits between the lights controller and the board LED pins.

---
 rtl/lights_pwm_driver_pkg.sv | 25 ++
 rtl/lights_pwm_driver_pwm_fade_channel.sv | 62 ++++++
 rtl/lights_pwm_driver.sv | 69 ++++++
 tb/tb_lights_pwm_driver.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lights_pwm_driver_pkg.sv
// Shared constants for the LED PWM driver: colour bit mapping, colour codes
// and default PWM/fade parameters.
package lights_pwm_driver_pkg;

  // Colour code bit positions for each LED channel
  localparam int unsigned CH_R = 2;
  localparam int unsigned CH_G = 1;
  localparam int unsigned CH_B = 0;

  // Colour codes from the lights controller
  localparam logic [2:0] COLOUR_OFF     = 3'b000;
  localparam logic [2:0] COLOUR_BLUE    = 3'b001;
  localparam logic [2:0] COLOUR_GREEN   = 3'b010;
  localparam logic [2:0] COLOUR_CYAN    = 3'b011;
  localparam logic [2:0] COLOUR_RED     = 3'b100;
  localparam logic [2:0] COLOUR_MAGENTA = 3'b101;
  localparam logic [2:0] COLOUR_YELLOW  = 3'b110;
  localparam logic [2:0] COLOUR_WHITE   = 3'b111;

  // Default parameter values
  localparam int unsigned PWM_W_DEF     = 8;
  localparam int unsigned MAX_DUTY_DEF  = 255;
  localparam int unsigned FADE_STEP_DEF = 16;

endpackage

// File: rtl/lights_pwm_driver_pwm_fade_channel.sv
// One LED channel: duty register that fades toward its on/off target once
// per PWM period, plus the registered PWM compare.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   on         1 = target is MAX_DUTY, 0 = target is 0
//   wrap       high on the last cycle of each PWM period
//   cnt        shared free-running PWM counter
//   enable     0 forces led low
//   led        registered PWM output
//   at_target  combinational duty == target flag
module pwm_fade_channel
  import lights_pwm_driver_pkg::*;
#(
  parameter int unsigned PWM_W     = PWM_W_DEF,
  parameter int unsigned MAX_DUTY  = MAX_DUTY_DEF,
  parameter int unsigned FADE_STEP = FADE_STEP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic             wrap,
  input  logic [PWM_W-1:0] cnt,
  input  logic             enable,
  output logic             led,
  output logic             at_target
);

  localparam logic [PWM_W-1:0] MAX_D = PWM_W'(MAX_DUTY);
  localparam logic [PWM_W-1:0] STEP  = PWM_W'(FADE_STEP);

  logic [PWM_W-1:0] duty;
  logic [PWM_W-1:0] duty_nxt;
  logic [PWM_W-1:0] target;

  assign target    = on ? MAX_D : '0;
  assign at_target = (duty == target);

  // Saturating step: the distance is compared before adding/subtracting so
  // the sum never leaves 0..MAX_DUTY.
  always_comb begin
    duty_nxt = duty;
    if (wrap) begin
      if (duty < target) begin
        duty_nxt = ((target - duty) <= STEP) ? target : duty + STEP;
      end else if (duty > target) begin
        duty_nxt = ((duty - target) <= STEP) ? target : duty - STEP;
      end
    end
  end

  // Duty and PWM output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      duty <= '0;
      led  <= 1'b0;
    end else begin
      duty <= duty_nxt;
      led  <= enable & (cnt < duty);
    end
  end

endmodule

// File: rtl/lights_pwm_driver.sv
// LED PWM driver: registers the colour code, runs the shared PWM counter and
// drives three fading PWM channels (red/green/blue).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   colour[2:0]    colour code, bit2=red, bit1=green, bit0=blue
//   enable         1 = drive LEDs, 0 = force outputs low
//   led_r/g/b      registered PWM outputs
//   settled        registered, 1 when every channel duty equals its target
module lights_pwm_driver
  import lights_pwm_driver_pkg::*;
#(
  parameter int unsigned PWM_W     = PWM_W_DEF,
  parameter int unsigned MAX_DUTY  = MAX_DUTY_DEF,
  parameter int unsigned FADE_STEP = FADE_STEP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] colour,
  input  logic       enable,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic       settled
);

  logic [2:0]       colour_q;
  logic [PWM_W-1:0] cnt;
  logic             wrap;
  logic [2:0]       at_target;
  logic [2:0]       led_v;

  // Last cycle of the PWM period: duties may only change here
  assign wrap = (cnt == {PWM_W{1'b1}});

  // Input register, free-running counter and settled flag
  always_ff @(posedge clk) begin
    if (rst) begin
      colour_q <= 3'b000;
      cnt      <= '0;
      settled  <= 1'b1;
    end else begin
      colour_q <= colour;
      cnt      <= cnt + PWM_W'(1);
      settled  <= &at_target;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    pwm_fade_channel #(
      .PWM_W    (PWM_W),
      .MAX_DUTY (MAX_DUTY),
      .FADE_STEP(FADE_STEP)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .on       (colour_q[i]),
      .wrap     (wrap),
      .cnt      (cnt),
      .enable   (enable),
      .led      (led_v[i]),
      .at_target(at_target[i])
    );
  end

  assign led_r = led_v[CH_R];
  assign led_g = led_v[CH_G];
  assign led_b = led_v[CH_B];

endmodule

// File: tb/tb_lights_pwm_driver.sv
// Bench for lights_pwm_driver: two instances (fade step 4 and 10, period 16)
// against a period-level reference model plus fixed expected sequences.
module tb_lights_pwm_driver;
  import lights_pwm_driver_pkg::*;

  localparam int PER = 16;
  localparam int MD  = 15;
  localparam int S0  = 4;
  localparam int S1  = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] colour;
  logic       enable;
  logic       led_r1, led_g1, led_b1, settled1;
  logic       led_r2, led_g2, led_b2, settled2;
  logic [2:0] leds1, leds2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lights_pwm_driver #(.PWM_W(4), .MAX_DUTY(15), .FADE_STEP(4)) u_dut1 (
    .clk(clk), .rst(rst), .colour(colour), .enable(enable),
    .led_r(led_r1), .led_g(led_g1), .led_b(led_b1), .settled(settled1));

  lights_pwm_driver #(.PWM_W(4), .MAX_DUTY(15), .FADE_STEP(10)) u_dut2 (
    .clk(clk), .rst(rst), .colour(colour), .enable(enable),
    .led_r(led_r2), .led_g(led_g2), .led_b(led_b2), .settled(settled2));

  assign leds1 = {led_r1, led_g1, led_b1};
  assign leds2 = {led_r2, led_g2, led_b2};

  // ---------------- reference model ----------------
  int         m_cnt;
  logic [2:0] m_cq;
  int         m_duty[2][3];
  logic [2:0] m_led[2];
  logic [1:0] m_settled;

  function automatic int toward(int d, int t, int s);
    if (d < t) return (d + s < t) ? d + s : t;
    if (d > t) return (d - s > t) ? d - s : t;
    return d;
  endfunction

  always @(posedge clk) begin : model
    int tgt;
    if (rst) begin
      m_cnt = 0;
      m_cq  = 3'b000;
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < 3; i++) m_duty[c][i] = 0;
        m_led[c] = 3'b000;
      end
      m_settled = 2'b11;
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_settled[c] = 1'b1;
        for (int i = 0; i < 3; i++) begin
          tgt = m_cq[i] ? MD : 0;
          m_led[c][i] = enable && (m_cnt < m_duty[c][i]);
          if (m_duty[c][i] != tgt) m_settled[c] = 1'b0;
        end
      end
      if (m_cnt == PER - 1) begin
        for (int c = 0; c < 2; c++)
          for (int i = 0; i < 3; i++)
            m_duty[c][i] = toward(m_duty[c][i], m_cq[i] ? MD : 0, (c == 0) ? S0 : S1);
      end
      m_cq  = colour;
      m_cnt = (m_cnt + 1) % PER;
    end
  end

  // ---------------- measurement helpers ----------------
  int wc[2][3];

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Move to the negedge where the outputs reflect cnt == 0
  task automatic align();
    while (m_cnt != 1) @(negedge clk);
  endtask

  // Count high cycles per channel over one aligned PWM period
  task automatic window();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 3; i++) wc[c][i] = 0;
    repeat (PER) begin
      for (int i = 0; i < 3; i++) begin
        if (leds1[i] === 1'b1) wc[0][i]++;
        if (leds2[i] === 1'b1) wc[1][i]++;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic exp_r;
    colour = 3'b111;
    enable = 1'b1;
    rst    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (leds1 !== 3'b000 || settled1 !== 1'b1) begin
        failures++;
        $display("FAIL reset_hold leds=%b settled=%b exp leds=000 settled=1", leds1, settled1);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k <= 2) begin
        checks++;
        if (settled1 !== (k == 1)) begin
          failures++;
          $display("FAIL reset_settled cycle=%0d got=%b exp=%b", k, settled1, (k == 1));
        end
      end
      // counter starts at 0: first wrap at edge 16, first high output at edge 17
      exp_r = (k == 17);
      checks++;
      if (led_r1 !== exp_r) begin
        failures++;
        $display("FAIL reset_cnt_start cycle=%0d led_r=%b exp=%b", k, led_r1, exp_r);
      end
    end
  endtask

  task automatic test_fade_up();
    int got[$];
    int exp_seq[4] = '{4, 8, 12, 15};
    do_reset();
    colour = 3'b100;
    enable = 1'b1;
    align();
    for (int w = 0; w < 10 && got.size() < 4; w++) begin
      window();
      if (got.size() > 0 || wc[0][2] != 0) got.push_back(wc[0][2]);
      checks++;
      if (wc[0][1] != 0 || wc[0][0] != 0) begin
        failures++;
        $display("FAIL fade_up_gb window=%0d g=%0d b=%0d exp 0 0", w, wc[0][1], wc[0][0]);
      end
    end
    checks++;
    if (got.size() != 4) begin
      failures++;
      $display("FAIL fade_up_timeout windows=%0d exp=4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] != exp_seq[i]) begin
          failures++;
          $display("FAIL fade_up_duty step=%0d got=%0d exp=%0d", i, got[i], exp_seq[i]);
        end
      end
    end
    checks++;
    if (settled1 !== 1'b1) begin
      failures++;
      $display("FAIL fade_up_settled got=%b exp=1", settled1);
    end
  endtask

  task automatic test_reversal();
    int exp_r[5] = '{8, 4, 0, 0, 0};
    int exp_b[5] = '{0, 4, 8, 12, 15};
    int n = 0;
    do_reset();
    colour = 3'b100;
    enable = 1'b1;
    while (m_duty[0][CH_R] != 8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL reversal_wait got=timeout exp=duty8");
    end
    colour = 3'b001;
    align();
    for (int w = 0; w < 5; w++) begin
      checks++;
      if (settled1 !== (w == 4)) begin
        failures++;
        $display("FAIL reversal_settled window=%0d got=%b exp=%b", w, settled1, (w == 4));
      end
      window();
      checks++;
      if (wc[0][CH_R] != exp_r[w] || wc[0][CH_B] != exp_b[w]) begin
        failures++;
        $display("FAIL reversal_duty window=%0d r=%0d b=%0d exp r=%0d b=%0d",
                 w, wc[0][CH_R], wc[0][CH_B], exp_r[w], exp_b[w]);
      end
    end
  endtask

  task automatic test_enable();
    int n = 0;
    do_reset();
    colour = 3'b010;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    while (settled1 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL enable_wait_settled got=timeout exp=settled");
    end
    enable = 1'b0;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (leds1 !== 3'b000) begin
        failures++;
        $display("FAIL enable_gate leds=%b exp=000", leds1);
      end
    end
    enable = 1'b1;
    align();
    window();
    checks++;
    if (wc[0][CH_G] != 15 || wc[0][CH_R] != 0 || wc[0][CH_B] != 0) begin
      failures++;
      $display("FAIL enable_resume g=%0d r=%0d b=%0d exp g=15 r=0 b=0",
               wc[0][CH_G], wc[0][CH_R], wc[0][CH_B]);
    end
  endtask

  task automatic test_saturation();
    int up[$];
    int dn[$];
    do_reset();
    colour = 3'b111;
    enable = 1'b1;
    align();
    for (int w = 0; w < 6 && up.size() < 2; w++) begin
      window();
      if (up.size() > 0 || wc[1][CH_R] != 0) up.push_back(wc[1][CH_R]);
      checks++;
      if (wc[1][CH_G] != wc[1][CH_R] || wc[1][CH_B] != wc[1][CH_R]) begin
        failures++;
        $display("FAIL sat_channels_equal r=%0d g=%0d b=%0d", wc[1][CH_R], wc[1][CH_G], wc[1][CH_B]);
      end
    end
    checks++;
    if (up.size() != 2 || up[0] != 10 || up[1] != 15) begin
      failures++;
      $display("FAIL sat_up got_n=%0d first=%0d second=%0d exp 10 15",
               up.size(), (up.size() > 0) ? up[0] : -1, (up.size() > 1) ? up[1] : -1);
    end
    colour = 3'b000;
    align();
    for (int w = 0; w < 6 && dn.size() < 2; w++) begin
      window();
      if (dn.size() > 0 || wc[1][CH_B] != 15) dn.push_back(wc[1][CH_B]);
    end
    checks++;
    if (dn.size() != 2 || dn[0] != 5 || dn[1] != 0) begin
      failures++;
      $display("FAIL sat_down got_n=%0d first=%0d second=%0d exp 5 0",
               dn.size(), (dn.size() > 0) ? dn[0] : -1, (dn.size() > 1) ? dn[1] : -1);
    end
  endtask

  task automatic test_sync_reset_mid_fade();
    int n = 0;
    logic exp_b;
    do_reset();
    colour = 3'b001;
    enable = 1'b1;
    while (m_duty[0][CH_B] != 8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    align();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (leds1 !== 3'b000 || leds2 !== 3'b000 || settled1 !== 1'b1) begin
      failures++;
      $display("FAIL midfade_reset leds1=%b leds2=%b settled=%b exp 000 000 1", leds1, leds2, settled1);
    end
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      exp_b = (k == 17);
      checks++;
      if (led_b1 !== exp_b) begin
        failures++;
        $display("FAIL midfade_restart cycle=%0d led_b=%b exp=%b", k, led_b1, exp_b);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 2500; k++) begin
      @(negedge clk);
      checks++;
      if (leds1 !== m_led[0] || settled1 !== m_settled[0] ||
          leds2 !== m_led[1] || settled2 !== m_settled[1]) begin
        failures++;
        $display("FAIL random cycle=%0d leds1=%b set1=%b leds2=%b set2=%b exp %b %b %b %b",
                 k, leds1, settled1, leds2, settled2, m_led[0], m_settled[0], m_led[1], m_settled[1]);
      end
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 29) == 0) colour = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 59) == 0) enable = ~enable;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    colour = 3'b000;
    enable = 1'b0;
    test_reset();
    test_fade_up();
    test_reversal();
    test_enable();
    test_saturation();
    test_sync_reset_mid_fade();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
